muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit implementing the RV32M/RV64M `funct3` operation set. It sits beside the ALU in the execute stage. The pipeline stalls on `busy_o` and takes `result_o` when `done_o` pulses. It replaces single-cycle ALU-only execution with a multi-cycle start/busy/done handshake, and it supports flush on branch redirect.

---
 rtl/muldiv_unit.sv | 129 ++++++++++++
 tb/tb_muldiv_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M multiply/divide with start/busy/done handshake and flush.
// Define MULDIV_FASTPATH_EN to complete divide-by-zero and signed-overflow divides without iterating.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     m_q, m_d, sval_q, sval_d, res_q, res_d;
    logic [2:0]          op_q, op_d;
    logic                neg_q, neg_d, an_q, an_d, spec_q, spec_d;

    logic                sa_en, sb_en, a_neg, b_neg, b_zero, ovf, spec;
    logic [XLEN-1:0]     a_mag, b_mag, spec_val, q_s, r_s, fin;
    logic [XLEN:0]       sum, rem_sh, diff;
    logic [2*XLEN-1:0]   acc_step, prod_s;

    assign sa_en    = op_i[2] ? ~op_i[0] : (op_i[1] ^ op_i[0]);
    assign sb_en    = op_i[2] ? ~op_i[0] : (op_i[1:0] == 2'b01);
    assign a_neg    = sa_en & a_i[XLEN-1];
    assign b_neg    = sb_en & b_i[XLEN-1];
    assign a_mag    = a_neg ? -a_i : a_i;
    assign b_mag    = b_neg ? -b_i : b_i;
    assign b_zero   = (b_i == '0);
    assign ovf      = ~op_i[0] & (a_i == MIN) & (&b_i);
    assign spec     = op_i[2] & (b_zero | ovf);
    assign spec_val = b_zero ? (op_i[1] ? a_i : '1) : (op_i[1] ? '0 : MIN);

    // Low half of acc holds multiplier bits (multiply) or dividend/quotient bits (divide).
    assign sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} + ({1'b0, m_q} & {(XLEN+1){acc_q[0]}});
    assign rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign diff     = rem_sh - {1'b0, m_q};
    assign acc_step = op_q[2] ? (diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                            : {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1})
                              : {sum, acc_q[XLEN-1:1]};
    assign prod_s   = neg_q ? -acc_step : acc_step;
    assign q_s      = neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    assign r_s      = an_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
    assign fin      = spec_q ? sval_q
                    : ~op_q[2] ? ((op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN])
                    : (op_q[1] ? r_s : q_s);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        m_d     = m_q;
        op_d    = op_q;
        neg_d   = neg_q;
        an_d    = an_q;
        spec_d  = spec_q;
        sval_d  = sval_q;
        res_d   = res_q;
        if (flush_i) begin
            state_d = IDLE;
        end else if (state_q == BUSY) begin
            acc_d = acc_step;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(XLEN - 1)) begin
                state_d = DONE;
                res_d   = fin;
            end
        end else if (start_i) begin
            state_d = BUSY;
            cnt_d   = '0;
            acc_d   = {{XLEN{1'b0}}, op_i[2] ? a_mag : b_mag};
            m_d     = op_i[2] ? b_mag : a_mag;
            op_d    = op_i;
            neg_d   = a_neg ^ b_neg;
            an_d    = a_neg;
            spec_d  = spec;
            sval_d  = spec_val;
`ifdef MULDIV_FASTPATH_EN
            if (spec) begin
                state_d = DONE;
                res_d   = spec_val;
            end
`endif
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            m_q     <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            an_q    <= 1'b0;
            spec_q  <= 1'b0;
            sval_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            an_q    <= an_d;
            spec_q  <= spec_d;
            sval_q  <= sval_d;
            res_q   <= res_d;
        end
    end

    assign busy_o   = (state_q == BUSY);
    assign done_o   = (state_q == DONE);
    assign result_o = res_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks of muldiv_unit at XLEN=32, with or without MULDIV_FASTPATH_EN.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, flush_i;
    logic [2:0]  op_i;
    logic [31:0] a_i, b_i;
    logic        busy_o, done_o;
    logic [31:0] result_o;
    int          errors = 0;
    int          checks = 0;

`ifdef MULDIV_FASTPATH_EN
    localparam int SL = 1;
`else
    localparam int SL = 33;
`endif

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
        .flush_i(flush_i), .busy_o(busy_o), .done_o(done_o), .result_o(result_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge: drive a request, let it be accepted, then drop start.
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        op_i = op; a_i = a; b_i = b; start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
    endtask

    // Cycle n counts from the accept edge; returns at the negedge of the done cycle.
    task automatic wait_done(input string tag, input logic [31:0] exp, input int lat,
                             input int n0, input int exp_busy);
        int n, nb, ov;
        bit got;
        n = n0; nb = 0; ov = 0; got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (busy_o) nb++;
            if (busy_o && done_o) ov++;
            if (done_o) got = 1'b1;
        end
        chk({tag, ".done_seen"}, 32'(got), 32'd1);
        chk({tag, ".latency"}, 32'(n), 32'(lat));
        chk({tag, ".busy_cycles"}, 32'(nb), 32'(exp_busy));
        chk({tag, ".busy_and_done"}, 32'(ov), 32'd0);
        chk({tag, ".result"}, result_o, exp);
    endtask

    initial begin
        int nd, nb;
        rst = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = '0; a_i = '0; b_i = '0;
        #3 rst = 1'b0;
        #1;
        chk("reset.busy", 32'(busy_o), 32'd0);
        chk("reset.done", 32'(done_o), 32'd0);
        chk("reset.result", result_o, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        start_op(3'b000, 32'd7, 32'hFFFF_FFFD);
        wait_done("mul", 32'hFFFF_FFEB, 33, 0, 32);
        @(negedge clk);
        chk("mul.done_one_cycle", 32'(done_o), 32'd0);

        start_op(3'b001, 32'h8000_0000, 32'h8000_0000);
        wait_done("mulh", 32'h4000_0000, 33, 0, 32);
        @(negedge clk);
        start_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("mulhu", 32'hFFFF_FFFE, 33, 0, 32);
        @(negedge clk);
        start_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("mulhsu", 32'hFFFF_FFFF, 33, 0, 32);
        @(negedge clk);

        start_op(3'b100, 32'hFFFF_FFEC, 32'd6);
        wait_done("div", 32'hFFFF_FFFD, 33, 0, 32);
        start_op(3'b110, 32'hFFFF_FFEC, 32'd6);
        wait_done("rem_b2b", 32'hFFFF_FFFE, 33, 0, 32);
        @(negedge clk);

        start_op(3'b101, 32'd5, 32'd0);
        wait_done("divu_by0", 32'hFFFF_FFFF, SL, 0, SL - 1);
        @(negedge clk);
        start_op(3'b111, 32'd5, 32'd0);
        wait_done("remu_by0", 32'd5, SL, 0, SL - 1);
        @(negedge clk);
        start_op(3'b100, 32'hFFFF_FFF9, 32'd0);
        wait_done("div_neg_by0", 32'hFFFF_FFFF, SL, 0, SL - 1);
        @(negedge clk);
        start_op(3'b110, 32'hFFFF_FFF9, 32'd0);
        wait_done("rem_neg_by0", 32'hFFFF_FFF9, SL, 0, SL - 1);
        @(negedge clk);
        start_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("rem_ovf", 32'd0, SL, 0, SL - 1);
        @(negedge clk);
        start_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_ovf", 32'h8000_0000, SL, 0, SL - 1);
        @(negedge clk);

        start_op(3'b101, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        chk("flush.busy_before", 32'(busy_o), 32'd1);
        flush_i = 1'b1; start_i = 1'b1; op_i = 3'b000; a_i = 32'd2; b_i = 32'd3;
        @(posedge clk);
        #1 flush_i = 1'b0; start_i = 1'b0;
        @(negedge clk);
        chk("flush.idle_busy", 32'(busy_o), 32'd0);
        chk("flush.idle_done", 32'(done_o), 32'd0);
        nd = 0; nb = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_o) nd++;
            if (busy_o) nb++;
        end
        chk("flush.no_done", 32'(nd), 32'd0);
        chk("flush.no_busy", 32'(nb), 32'd0);
        chk("flush.result_kept", result_o, 32'h8000_0000);

        start_op(3'b000, 32'd6, 32'd7);
        repeat (4) @(negedge clk);
        op_i = 3'b101; a_i = 32'd1; b_i = 32'd1; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        wait_done("start_in_busy", 32'd42, 33, 5, 27);
        nb = 0;
        repeat (3) begin
            @(negedge clk);
            if (busy_o || done_o) nb++;
        end
        chk("start_in_busy.not_queued", 32'(nb), 32'd0);

        start_op(3'b000, 32'd7, 32'd3);
        repeat (5) @(negedge clk);
        chk("rst_mid.busy_before", 32'(busy_o), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("rst_mid.busy", 32'(busy_o), 32'd0);
        chk("rst_mid.done", 32'(done_o), 32'd0);
        chk("rst_mid.result", result_o, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        start_op(3'b011, 32'd3, 32'd5);
        wait_done("mulhu_after_rst", 32'd0, 33, 0, 32);
        @(negedge clk);
        start_op(3'b000, 32'd3, 32'd5);
        wait_done("mul_after_rst", 32'd15, 33, 0, 32);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
